// File: rtl/mul_issue_ctrl_pkg.sv
// Shared encodings for the multiply issue front-end: RV32M op codes, FSM states
// and the default multiplier latency.
package mul_issue_ctrl_pkg;

  localparam int MUL_LAT_DEFAULT = 32;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } mul_state_e;

endpackage

// File: rtl/mul_issue_ctrl_hi_fix.sv
// Result selection for RV32M multiplies: picks lo or hi of the signed 64-bit
// product and turns the signed high half into the MULHSU/MULHU high half.
module mul_hi_fix
  import mul_issue_ctrl_pkg::*;
(
  input  mul_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] mul_res,
  output logic [31:0] result
);

  logic [31:0] hi_s;
  logic [31:0] fix_b_neg;
  logic [31:0] fix_a_neg;

  // A negative-looking operand that is really unsigned was under-weighted by
  // 2^32 times the other operand; add that back into the high half.
  assign hi_s      = mul_res[63:32];
  assign fix_b_neg = b[31] ? a : 32'd0;
  assign fix_a_neg = a[31] ? b : 32'd0;

  always_comb begin
    // NOTE: assign a default before the case so no path leaves result unassigned (no latch).
    result = mul_res[31:0];
    unique case (op)
      MUL_OP_MUL:    result = mul_res[31:0];
      MUL_OP_MULH:   result = hi_s;
      MUL_OP_MULHSU: result = hi_s + fix_b_neg;
      MUL_OP_MULHU:  result = hi_s + fix_a_neg + fix_b_neg;
      default:       result = mul_res[31:0];
    endcase
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue/return control in front of the 32-cycle shift-add multiplier.
// Optional macro MUL_REUSE_EN: reuse the last product when operands repeat.
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int TAG_W   = 5,
  parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             mul_start,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic             mul_finish,
  input  logic [63:0]      mul_res
);

  localparam int               CNT_W      = $clog2(MUL_LAT + 3);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(MUL_LAT + 2);

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q;
  mul_op_e          op_q;

  logic             accept;
  logic             busy_flush;
  logic             mul_done;
  logic             reuse_hit;
  logic [63:0]      reuse_res;

  mul_op_e          fix_op;
  logic [31:0]      fix_a, fix_b, fix_result;
  logic [63:0]      fix_res;

  assign req_ready  = (state_q == ST_IDLE);
  assign mul_start  = (state_q == ST_START);
  assign resp_valid = (state_q == ST_RESP);

  assign accept     = req_ready && req_valid && !flush;
  assign busy_flush = flush && (state_q inside {ST_START, ST_WAIT});
  assign mul_done   = (state_q == ST_WAIT) && mul_finish && !flush;

`ifdef MUL_REUSE_EN
  logic        reuse_valid_q;
  logic [31:0] reuse_a_q, reuse_b_q;
  logic [63:0] reuse_res_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reuse_valid_q <= 1'b0;
    end else if (busy_flush) begin
      reuse_valid_q <= 1'b0;
    end else if (mul_done) begin
      reuse_valid_q <= 1'b1;
    end
  end

  // NOTE: the stored operands/product are only read when reuse_valid_q is set, so they need no reset.
  always_ff @(posedge clk) begin
    if (mul_done) begin
      reuse_a_q   <= mul_a;
      reuse_b_q   <= mul_b;
      reuse_res_q <= mul_res;
    end
  end

  assign reuse_hit = reuse_valid_q && (req_a == reuse_a_q) && (req_b == reuse_b_q);
  assign reuse_res = reuse_res_q;
`else
  assign reuse_hit = 1'b0;
  assign reuse_res = 64'd0;
`endif

  // In IDLE the selector serves the reuse path from the live request; otherwise
  // it corrects the multiplier product for the latched request.
  always_comb begin
    fix_op  = op_q;
    fix_a   = mul_a;
    fix_b   = mul_b;
    fix_res = mul_res;
    if (state_q == ST_IDLE) begin
      fix_op  = mul_op_e'(req_op);
      fix_a   = req_a;
      fix_b   = req_b;
      fix_res = reuse_res;
    end
  end

  mul_hi_fix u_hi_fix (
    .op      (fix_op),
    .a       (fix_a),
    .b       (fix_b),
    .mul_res (fix_res),
    .result  (fix_result)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = reuse_hit ? ST_RESP : ST_START;
      ST_START: state_d = flush ? ST_DRAIN : ST_WAIT;
      // Finish is only trusted from WAIT on; in START it still shows the previous op.
      ST_WAIT:  if (flush) state_d = ST_DRAIN;
                else if (mul_finish) state_d = ST_RESP;
      ST_RESP:  if (flush || resp_ready) state_d = ST_IDLE;
      ST_DRAIN: if (mul_finish || drain_cnt_q == '0) state_d = ST_IDLE;
      default:  state_d = ST_DRAIN;
    endcase
  end

  // Reset lands in DRAIN: the multiplier keeps running across our reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q     <= ST_DRAIN;
      drain_cnt_q <= DRAIN_LOAD;
      op_q        <= MUL_OP_MUL;
      mul_a       <= 32'd0;
      mul_b       <= 32'd0;
      resp_data   <= 32'd0;
      resp_tag    <= '0;
    end else begin
      state_q <= state_d;

      if (busy_flush) begin
        drain_cnt_q <= DRAIN_LOAD;
      end else if (state_q == ST_DRAIN && drain_cnt_q != '0) begin
        drain_cnt_q <= drain_cnt_q - CNT_W'(1);
      end

      if (accept) begin
        op_q     <= mul_op_e'(req_op);
        mul_a    <= req_a;
        mul_b    <= req_b;
        resp_tag <= req_tag;
        if (reuse_hit) resp_data <= fix_result;
      end

      if (mul_done) resp_data <= fix_result;
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Self-checking bench for mul_issue_ctrl: behavioural multiplier model, directed
// vector table, multi-cycle corner sequences and randomized requests.
module tb_mul_issue_ctrl;

  localparam int TAG_W   = 5;
  localparam int MUL_LAT = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             mul_start;
  logic [31:0]      mul_a, mul_b;
  logic             mul_finish = 1'b0;
  logic [63:0]      mul_res    = 64'd0;

  int n_checks = 0;
  int n_errors = 0;
  int start_cnt = 0;
  int busy_start_err = 0;
  int m_cnt = 0;
  logic [63:0] m_res;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_finish(mul_finish), .mul_res(mul_res)
  );

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference: plain 64-bit products of the operands as RV32M defines their signedness.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'd0:    begin p = sx(a) * sx(b);                 return p[31:0];  end
      2'd1:    begin p = sx(a) * sx(b);                 return p[63:32]; end
      2'd2:    begin p = sx(a) * {32'd0, b};            return p[63:32]; end
      default: begin p = {32'd0, a} * {32'd0, b};       return p[63:32]; end
    endcase
  endfunction

  // Multiplier model: start clears finish; product appears with finish MUL_LAT edges later.
  always @(posedge clk) begin
    if (mul_start) begin
      m_cnt      <= MUL_LAT;
      mul_finish <= 1'b0;
      m_res      <= sx(mul_a) * sx(mul_b);
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        mul_finish <= 1'b1;
        mul_res    <= m_res;
      end
    end
  end

  always @(negedge clk) begin
    if (mul_start === 1'b1) begin
      start_cnt++;
      if (m_cnt != 0) busy_start_err++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag);
    int n = 0;
    req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (req_ready !== 1'b1) begin
      check("accept_timeout", req_ready, 1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic collect(output logic [31:0] data, output logic [TAG_W-1:0] tag);
    int n = 0;
    data = 'x; tag = 'x;
    while (resp_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (resp_valid !== 1'b1) begin
      check("resp_timeout", resp_valid, 1);
      return;
    end
    data = resp_data; tag = resp_tag;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic do_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input string name);
    logic [31:0]      d;
    logic [TAG_W-1:0] t;
    issue(op, a, b, tag);
    collect(d, t);
    check({name, "_data"}, d, ref_result(op, a, b));
    check({name, "_tag"}, t, tag);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_resp_valid"}, resp_valid, 0);
    check({name, "_req_ready"},  req_ready,  0);
    check({name, "_mul_start"},  mul_start,  0);
    check({name, "_resp_data"},  resp_data,  0);
    check({name, "_resp_tag"},   resp_tag,   0);
    check({name, "_mul_a"},      mul_a,      0);
    check({name, "_mul_b"},      mul_b,      0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] edge_vals [4];
    edge_vals[0] = 32'h0000_0000; edge_vals[1] = 32'h8000_0000;
    edge_vals[2] = 32'hFFFF_FFFF; edge_vals[3] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  typedef struct {
    logic [1:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0]      d0;
    logic [TAG_W-1:0] t0;
    int               s0;
    int               n;
    bit               stable;

    vecs[0] = '{2'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB};
    vecs[1] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000};
    vecs[2] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE};
    vecs[3] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF};
    vecs[4] = '{2'd3, 32'h8000_0000, 32'h0000_0002, 5'd5,  32'h0000_0001};
    vecs[5] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000};
    vecs[6] = '{2'd0, 32'h0000_0000, 32'hFFFF_FFFF, 5'd7,  32'h0000_0000};
    vecs[7] = '{2'd2, 32'h8000_0000, 32'h8000_0000, 5'd31, 32'hC000_0000};

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    flush = 1'b0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    @(negedge clk);
    check("drain_holds_ready_low", req_ready, 0);
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("drain_exit", req_ready, 1);

    // Directed vectors with exactly one start pulse each.
    for (int i = 0; i < 8; i++) begin
      logic [TAG_W-1:0] t;
      s0 = start_cnt;
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      collect(d0, t);
      check($sformatf("vec%0d_data", i), d0, vecs[i].exp);
      check($sformatf("vec%0d_tag", i), t, vecs[i].tag);
      check($sformatf("vec%0d_starts", i), start_cnt - s0, 1);
    end

    // Backpressure: response held for 10 cycles.
    issue(2'd1, 32'h1234_5678, 32'hDEAD_BEEF, 5'd9);
    n = 0;
    while (resp_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    check("bp_resp_valid", resp_valid, 1);
    d0 = resp_data; t0 = resp_tag; s0 = start_cnt; stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (resp_data !== d0 || resp_tag !== t0 || resp_valid !== 1'b1 || req_ready !== 1'b0)
        stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    check("bp_no_start", start_cnt - s0, 0);
    check("bp_data", d0, ref_result(2'd1, 32'h1234_5678, 32'hDEAD_BEEF));
    check("bp_tag", t0, 5'd9);
    resp_ready = 1'b1; @(negedge clk); resp_ready = 1'b0;
    check("bp_released", resp_valid, 0);

    // Flush in WAIT: result discarded, next request waits for the multiplier.
    issue(2'd0, 32'h0000_1111, 32'h0000_2222, 5'd3);
    repeat (5) @(negedge clk);
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    check("flush_wait_no_resp", resp_valid, 0);
    check("flush_wait_drain", req_ready, 0);
    s0 = start_cnt;
    do_txn(2'd3, 32'hF000_000F, 32'h8765_4321, 5'd10, "after_flush");
    check("after_flush_starts", start_cnt - s0, 1);

    // Flush in IDLE ignores the concurrent request.
    s0 = start_cnt;
    req_op = 2'd0; req_a = 32'd5; req_b = 32'd6; req_tag = 5'd11;
    req_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("flush_idle_ready", req_ready, 1);
    @(negedge clk);
    check("flush_idle_no_start", start_cnt - s0, 0);

    // Flush in RESP drops the response.
    issue(2'd1, 32'h0BAD_F00D, 32'h0000_0003, 5'd12);
    n = 0;
    while (resp_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    check("flush_resp_drop", resp_valid, 0);
    check("flush_resp_idle", req_ready, 1);

    // Reset pulse during WAIT.
    issue(2'd3, 32'hCAFE_BABE, 32'h1357_9BDF, 5'd13);
    repeat (5) @(negedge clk);
    rst_n = 1'b0; @(negedge clk);
    check_reset_outputs("midwait_reset");
    rst_n = 1'b1;
    do_txn(2'd2, 32'h8000_0001, 32'hFFFF_FFF0, 5'd14, "after_reset");

    // Same operands back to back: MULH then MUL.
    do_txn(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15, "pair_mulh");
    s0 = start_cnt;
    issue(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd16);
`ifdef MUL_REUSE_EN
    check("reuse_fast_resp", resp_valid, 1);
`endif
    collect(d0, t0);
    check("pair_mul_data", d0, ref_result(2'd0, 32'h1234_5678, 32'h9ABC_DEF0));
    check("pair_mul_tag", t0, 5'd16);
`ifdef MUL_REUSE_EN
    check("reuse_no_start", start_cnt - s0, 0);
`else
    check("pair_mul_starts", start_cnt - s0, 1);
`endif

    // Randomized requests against the reference model.
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = ($urandom_range(0, 4) == 0) ? a : pick_operand();
      do_txn(op, a, b, TAG_W'($urandom), $sformatf("rand%0d", i));
    end

    check("no_start_while_busy", busy_start_err, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
